// File: rtl/reg_writeback.sv
// Writeback stage: commits memory-op results into the 32x32 register file, with two read ports.
// Optional same-cycle read forwarding is enabled by defining REG_WB_BYPASS_EN.
module reg_writeback #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] m1,
    input  logic [DW-1:0] m2,
    input  logic [4:0]    wa1,
    input  logic [4:0]    wa2,
    input  logic [3:0]    wb_op,
    input  logic          proceed,
    input  logic [4:0]    ra1,
    input  logic [4:0]    ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [31:0]   retire_cnt,
    output logic          wb_illegal,
    output logic          wb_busy
);

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_W1   = 4'h1;
    localparam logic [3:0] OP_W2   = 4'h2;
    localparam logic [3:0] OP_BOTH = 4'h3;
    localparam logic [3:0] OP_SWAP = 4'h4;

    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic [31:0]   retire_cnt_q, retire_cnt_d;
    logic          illegal_q, illegal_d;
    logic          busy_q, busy_d;

    logic [3:0]    eop;
    logic          lane1_en, lane2_en;
    logic          we1, we2;

    assign eop = proceed ? wb_op : OP_NONE;

    // Op decode into raw lane enables plus the illegal flag.
    always_comb begin
        lane1_en  = 1'b0;
        lane2_en  = 1'b0;
        illegal_d = 1'b0;
        case (eop)
            OP_NONE: ;
            OP_W1:   lane1_en = 1'b1;
            OP_W2:   lane2_en = 1'b1;
            OP_BOTH: begin
                lane1_en = 1'b1;
                lane2_en = 1'b1;
            end
            OP_SWAP: begin
                if (wa1 != wa2) begin
                    lane1_en = 1'b1;
                    lane2_en = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Performed writes: r0 writes dropped, lane 2 wins a shared destination, nothing in reset.
    always_comb begin
        we2 = lane2_en && (wa2 != 5'd0) && !rst;
        we1 = lane1_en && (wa1 != 5'd0) && !rst && !(we2 && (wa1 == wa2));
    end

    always_comb begin
        regs_d = regs_q;
        if (we1) regs_d[wa1] = m1;
        if (we2) regs_d[wa2] = m2;
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q + {31'd0, we1} + {31'd0, we2};
        busy_d       = we1 | we2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            retire_cnt_q <= '0;
            illegal_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_q    <= illegal_d;
            busy_q       <= busy_d;
        end
    end

`ifdef REG_WB_BYPASS_EN
    // Forward the value being committed this cycle; we2 is checked first so a conflict yields m2.
    always_comb begin
        if (ra1 == 5'd0)                rd1 = '0;
        else if (we2 && (wa2 == ra1))   rd1 = m2;
        else if (we1 && (wa1 == ra1))   rd1 = m1;
        else                            rd1 = regs_q[ra1];

        if (ra2 == 5'd0)                rd2 = '0;
        else if (we2 && (wa2 == ra2))   rd2 = m2;
        else if (we1 && (wa1 == ra2))   rd2 = m1;
        else                            rd2 = regs_q[ra2];
    end
`else
    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
    end
`endif

    assign retire_cnt = retire_cnt_q;
    assign wb_illegal = illegal_q;
    assign wb_busy    = busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed plan steps plus random traffic against a register-file model.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m1, m2;
    logic [4:0]  wa1, wa2, ra1, ra2;
    logic [3:0]  wb_op;
    logic        proceed;
    logic [31:0] rd1, rd2, retire_cnt;
    logic        wb_illegal, wb_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;
    logic        model_busy, model_ill;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .m1         (m1),
        .m2         (m2),
        .wa1        (wa1),
        .wa2        (wa2),
        .wb_op      (wb_op),
        .proceed    (proceed),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .retire_cnt (retire_cnt),
        .wb_illegal (wb_illegal),
        .wb_busy    (wb_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check reads before the edge, update the model, check after.
    task automatic cycle(input logic r, input logic p, input logic [3:0] op,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic [31:0] nxt [32];
        logic [3:0]  e;
        logic        l1, l2, ill;
        int          n;
        @(negedge clk);
        rst = r; proceed = p; wb_op = op; wa1 = a1; wa2 = a2;
        m1 = d1; m2 = d2; ra1 = r1; ra2 = r2;
        #1;
        e   = p ? op : 4'h0;
        l1  = (e == 1) || (e == 3) || (e == 4 && a1 != a2);
        l2  = (e == 2) || (e == 3) || (e == 4 && a1 != a2);
        ill = (e > 4) || (e == 4 && a1 == a2);
        nxt = model_regs;
        n = 0;
        if (l1 && a1 != 0) begin nxt[a1] = d1; n++; end
        if (l2 && a2 != 0) begin
            nxt[a2] = d2;
            if (!(l1 && a1 == a2)) n++;
        end
        nxt[0] = 32'h0;
        if (!r) begin
`ifdef REG_WB_BYPASS_EN
            chk("rd1_pre", rd1, nxt[r1]);
            chk("rd2_pre", rd2, nxt[r2]);
`else
            chk("rd1_pre", rd1, model_regs[r1]);
            chk("rd2_pre", rd2, model_regs[r2]);
`endif
        end
        @(posedge clk);
        #1;
        if (r) begin
            foreach (model_regs[i]) model_regs[i] = 32'h0;
            model_cnt = 0; model_busy = 0; model_ill = 0;
        end else begin
            model_regs = nxt;
            model_cnt  = model_cnt + 32'(n);
            model_busy = (n > 0);
            model_ill  = ill;
        end
        chk("rd1", rd1, model_regs[r1]);
        chk("rd2", rd2, model_regs[r2]);
        chk("retire_cnt", retire_cnt, model_cnt);
        chk("wb_busy", {31'd0, wb_busy}, {31'd0, model_busy});
        chk("wb_illegal", {31'd0, wb_illegal}, {31'd0, model_ill});
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(1'b0, 1'b1, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, r1, r2);
    endtask

    task automatic random_cycles(input int count);
        logic [3:0] op;
        for (int i = 0; i < count; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0), op,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        rst = 1'b1; proceed = 0; wb_op = 0; wa1 = 0; wa2 = 0;
        m1 = 0; m2 = 0; ra1 = 0; ra2 = 0;
        foreach (model_regs[i]) model_regs[i] = 32'h0;
        model_cnt = 0; model_busy = 0; model_ill = 0;

        // Initial reset, then random preload traffic.
        cycle(1'b1, 1'b0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        random_cycles(150);

        // Two reset cycles, then every register must read zero.
        cycle(1'b1, 1'b1, 4'h3, 5'd1, 5'd2, $urandom, $urandom, 5'd1, 5'd2);
        cycle(1'b1, 1'b1, 4'h3, 5'd3, 5'd4, $urandom, $urandom, 5'd3, 5'd4);
        for (int i = 0; i < 16; i++) idle(5'(i), 5'(31 - i));

        // Dual write.
        cycle(1'b0, 1'b1, 4'h3, 5'd5, 5'd6, 32'h11111111, 32'h22222222, 5'd5, 5'd6);
        idle(5'd5, 5'd6);

        // Same-destination conflict, then a discarded r0 write.
        cycle(1'b0, 1'b1, 4'h3, 5'd9, 5'd9, 32'hAAAA0000, 32'h0000BBBB, 5'd9, 5'd0);
        cycle(1'b0, 1'b1, 4'h1, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 5'd0, 5'd9);

        // Condition gate, reserved op, illegal swap.
        cycle(1'b0, 1'b0, 4'h3, 5'd7, 5'd8, 32'h12345678, 32'h87654321, 5'd7, 5'd8);
        cycle(1'b0, 1'b1, 4'hF, 5'd10, 5'd11, 32'h1, 32'h2, 5'd10, 5'd11);
        idle(5'd7, 5'd8);
        cycle(1'b0, 1'b1, 4'h4, 5'd3, 5'd3, 32'h33333333, 32'h44444444, 5'd3, 5'd0);
        idle(5'd3, 5'd3);
        cycle(1'b0, 1'b1, 4'h4, 5'd13, 5'd14, 32'h13131313, 32'h14141414, 5'd13, 5'd14);

        // Read of a register while it is being written.
        cycle(1'b0, 1'b1, 4'h1, 5'd12, 5'd0, 32'hCAFEF00D, 32'h0, 5'd12, 5'd12);
        idle(5'd12, 5'd0);
        cycle(1'b0, 1'b1, 4'h3, 5'd15, 5'd15, 32'h01010101, 32'h02020202, 5'd15, 5'd15);

        // Reset during a write.
        cycle(1'b0, 1'b1, 4'h3, 5'd4, 5'd5, 32'h44440000, 32'h55550000, 5'd4, 5'd5);
        cycle(1'b1, 1'b1, 4'h3, 5'd4, 5'd5, 32'h4444FFFF, 32'h5555FFFF, 5'd4, 5'd5);
        idle(5'd4, 5'd5);

        random_cycles(200);

        // Counter wrap via backdoor preload.
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        idle(5'd1, 5'd2);
        release dut.retire_cnt_q;
        cycle(1'b0, 1'b1, 4'h1, 5'd20, 5'd0, 32'h20202020, 32'h0, 5'd20, 5'd0);
        cycle(1'b0, 1'b1, 4'h3, 5'd21, 5'd22, 32'h21, 32'h22, 5'd21, 5'd22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Final pipeline stage. Sits directly downstream of the memory-op stage and its passthrough register.
- Consumes the two memory-op results (m1, m2) together with the delayed destination indices, writeback op and proceed flag.
- Commits the results into the 32x32 general register file.
- Exposes two combinational read ports to decode, plus retire/illegal status for debug.

Parameters:
- NREGS, 32, number of architectural registers; index width fixed at 5 bits.
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- m1  input  DW  result lane 1 from memory-op stage
- m2  input  DW  result lane 2 from memory-op stage
- wa1  input  5  destination register for lane 1 (passthrough q_a1)
- wa2  input  5  destination register for lane 2 (passthrough q_a2)
- wb_op  input  4  writeback op (passthrough q_op)
- proceed  input  1  condition-test result (passthrough q_proceed)
- ra1  input  5  decode read address 1
- ra2  input  5  decode read address 2
- rd1  output  DW  read data 1
- rd2  output  DW  read data 2
- retire_cnt  output  32  count of committed register writes
- wb_illegal  output  1  registered flag: reserved wb_op seen last cycle
- wb_busy  output  1  registered: a write committed last cycle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, on a rising edge with rst=1:
  - all NREGS registers cleared to 0;
  - retire_cnt=0, wb_illegal=0, wb_busy=0;
  - any write presented in that cycle is dropped.
- Effective op: eop = proceed ? wb_op : 4'h0.
- eop decode:
  - 0 no write;
  - 1 write m1 to wa1;
  - 2 write m2 to wa2;
  - 3 write both;
  - 4 swap-commit: write m1 to wa1 and m2 to wa2, identical to 3 but permitted only when wa1!=wa2, otherwise illegal;
  - 5..15 reserved: no write, wb_illegal=1 next cycle.
- Alignment: m1/m2 are valid in the same cycle as the passthrough outputs. Writes commit on the rising edge ending that cycle; latency from presentation to register update is 1 edge.
- Register 0 is hardwired zero: writes to index 0 are discarded, and reads of index 0 return 0.
- Same-destination conflict (op 3 with wa1==wa2!=0): lane 2 wins. Only one write is counted.
- retire_cnt:
  - increments by the number of writes actually performed (0, 1 or 2), excluding discarded r0 writes and the losing lane of a conflict;
  - wraps modulo 2^32.
- wb_busy is 1 on the cycle after any performed write, else 0.
- wb_illegal:
  - 1 for exactly one cycle after a reserved eop, or after op 4 with wa1==wa2;
  - no writes are performed in that case.
- Read ports:
  - rd1/rd2 are combinational from the array (addresses ra1/ra2), without bypass.
  - A write on edge N is visible on the reads from after edge N.
- Reset mid-operation: a write in the reset cycle is lost and the array is still zeroed. Normal operation resumes on the first edge with rst=0.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined:
  - rd1/rd2 forward the write data being committed in the current cycle when ra matches a performed-write destination (not r0);
  - on a lane-2-wins conflict the forwarded value is m2;
  - reserved or illegal ops never forward.
- Undefined: no forwarding; reads return array contents only, so decode sees the new value one cycle later.

Test Plan:
1. Reset check: assert rst for 2 cycles after random preload writes -> all 32 reads return 0, retire_cnt=0, wb_illegal=0, wb_busy=0.
2. Dual write: proceed=1, wb_op=3, wa1=5, m1=32'h11111111, wa2=6, m2=32'h22222222 -> next cycle rd(5)=11111111, rd(6)=22222222, retire_cnt=2, wb_busy=1.
3. Conflict and r0:
   - wb_op=3, wa1=wa2=9, m1=AAAA0000, m2=0000BBBB -> r9=0000BBBB, retire_cnt +1.
   - then wb_op=1, wa1=0, m1=DEADBEEF -> rd(0)=0, retire_cnt unchanged, wb_busy=0.
4. Condition gate and illegal:
   - proceed=0, wb_op=3, wa1=7, m1=12345678 -> r7 unchanged.
   - proceed=1, wb_op=4'hF -> no write, wb_illegal=1 for one cycle.
   - wb_op=4 with wa1=wa2=3 -> wb_illegal=1, r3 unchanged.
5. Bypass: ra1=12 held, wb_op=1, wa1=12, m1=CAFEF00D.
   - With REG_WB_BYPASS_EN: rd1=CAFEF00D in the same cycle.
   - Without: rd1 shows the old value, then CAFEF00D after the edge.
6. Reset mid-write, plus wrap:
   - rst=1 with wb_op=3 to r4/r5 -> r4=r5=0 after the edge.
   - Separately: force retire_cnt to FFFFFFFF via 2^32-1 counted writes (or a bench backdoor), then one write -> retire_cnt=0.
